// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers a sample value from the duty cycle of an asynchronous
// PWM waveform. It measures high time and frame length between rising edges,
// and reports lock while the frames stay within PULSE_PERIOD +/- TOLERANCE.
// Optional feature macro: PWM_DEC_GLITCH_FILTER_EN. When it is defined, a
// registered 3-sample majority filter follows the synchronizer, which adds
// 2 cycles of latency.
//
// Output semantics: sample_valid is a single-cycle pulse with no ready or
// back-pressure. sample and locked are updated only in the cycle
// sample_valid is high, and they hold their values between pulses.
module pwm_decoder #(
  parameter int PULSE_PERIOD = 2048,
  parameter int INPUT_BITS   = 6,
  parameter int TOLERANCE    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm_in,
  output logic [INPUT_BITS-1:0] sample,
  output logic                  sample_valid,
  output logic                  locked,
  output logic                  state_dbg
);

  localparam int PERIOD_LOG2 = $clog2(PULSE_PERIOD);
  localparam int SHIFT       = PERIOD_LOG2 - INPUT_BITS;
  localparam int HIGH_W      = PERIOD_LOG2 + 1;
  localparam int LIMIT       = PULSE_PERIOD + TOLERANCE;
  localparam int PERIOD_W    = $clog2(LIMIT + 1);

  localparam logic [PERIOD_W-1:0] LIMIT_CNT = PERIOD_W'(LIMIT);
  localparam logic [PERIOD_W-1:0] LOCK_MIN  = PERIOD_W'(PULSE_PERIOD - TOLERANCE);
  localparam logic [HIGH_W-1:0]   SAT_MAX   = HIGH_W'((1 << INPUT_BITS) - 1);

  typedef enum logic {
    ST_SYNC    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t                  state;
  logic                    sync_q1;
  logic                    sync_q2;
  logic                    s;
  logic                    s_d;
  logic                    rise_q;
  logic [PERIOD_W-1:0]     period_cnt;
  logic [HIGH_W-1:0]       high_cnt;
  logic [HIGH_W-1:0]       high_shifted;
  logic [INPUT_BITS-1:0]   sample_next;
  logic                    at_limit;
  logic                    in_window;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic hist_q1;
  logic hist_q2;

  // Registered majority of the last three synchronizer samples; single-cycle pulses vanish.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q1 <= 1'b0;
      hist_q2 <= 1'b0;
      s       <= 1'b0;
    end else begin
      hist_q1 <= sync_q2;
      hist_q2 <= hist_q1;
      s       <= (sync_q2 & hist_q1) | (sync_q2 & hist_q2) | (hist_q1 & hist_q2);
    end
  end
`else
  assign s = sync_q2;
`endif

  // Delayed copy of s and a registered rising-edge flag. rise_q lines up
  // with s_d, so the FSM works on s_d as its view of the input level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_d    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s_d    <= s;
      rise_q <= s & ~s_d;
    end
  end

  assign at_limit  = (period_cnt == LIMIT_CNT);
  assign in_window = (period_cnt >= LOCK_MIN) && (period_cnt <= LIMIT_CNT);
  assign state_dbg = (state == ST_MEASURE);

  // Scale the high count down to the sample width, saturating at full scale.
  always_comb begin
    high_shifted = high_cnt >> SHIFT;
    sample_next  = high_shifted[INPUT_BITS-1:0];
    if (high_shifted > SAT_MAX) begin
      sample_next = '1;
    end
  end

  // Frame FSM. A rising edge takes priority over the timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_SYNC;
      period_cnt   <= '0;
      high_cnt     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (rise_q) begin
            state      <= ST_MEASURE;
            period_cnt <= PERIOD_W'(1);
            high_cnt   <= HIGH_W'(1);
          end else if (at_limit) begin
            sample_valid <= 1'b1;
            sample       <= '0;
            locked       <= 1'b0;
            period_cnt   <= PERIOD_W'(1);
          end else begin
            period_cnt <= period_cnt + PERIOD_W'(1);
          end
        end
        ST_MEASURE: begin
          if (rise_q) begin
            sample_valid <= 1'b1;
            sample       <= sample_next;
            locked       <= in_window;
            period_cnt   <= PERIOD_W'(1);
            high_cnt     <= HIGH_W'(1);
          end else if (at_limit) begin
            sample_valid <= 1'b1;
            sample       <= sample_next;
            locked       <= 1'b0;
            period_cnt   <= PERIOD_W'(1);
            high_cnt     <= {{(HIGH_W-1){1'b0}}, s_d};
          end else begin
            period_cnt <= period_cnt + PERIOD_W'(1);
            if (s_d) begin
              high_cnt <= high_cnt + HIGH_W'(1);
            end
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: drives PWM frames into pwm_decoder and checks every
// emitted sample against an input-level frame model.
module tb_pwm_decoder;

  localparam int PP    = 2048;
  localparam int IB    = 6;
  localparam int TOL   = 2;
  localparam int LIMIT = PP + TOL;
  localparam int SHIFT = $clog2(PP) - IB;
`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int PIPE  = 4;
`else
  localparam int PIPE  = 3;
`endif

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          pwm_in = 1'b0;
  logic [IB-1:0] sample;
  logic          sample_valid;
  logic          locked;
  logic          state_dbg;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;

  logic [IB:0]   exp_q[$];
  int            exp_cyc_q[$];
  logic [IB-1:0] hold_s = '0;
  logic          hold_l = 1'b0;

  logic m_prev = 1'b0;
  logic m_h1   = 1'b0;
  logic m_h2   = 1'b0;
  bit   m_measure = 1'b0;
  int   m_len = 0;
  int   m_hc  = 0;
  int   m_deadline = 0;

  pwm_decoder #(
    .PULSE_PERIOD(PP),
    .INPUT_BITS  (IB),
    .TOLERANCE   (TOL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .sample      (sample),
    .sample_valid(sample_valid),
    .locked      (locked),
    .state_dbg   (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IB-1:0] sat_sample(input int hc);
    int v;
    v = hc >> SHIFT;
    if (v > (1 << IB) - 1) v = (1 << IB) - 1;
    return v[IB-1:0];
  endfunction

  task automatic push_exp(input logic [IB-1:0] s, input logic lk, input int at);
    exp_q.push_back({lk, s});
    exp_cyc_q.push_back(at);
  endtask

  // Frame model fed with each input bit; e is the clock edge that samples it.
  task automatic model_step(input logic v, input int e);
    logic m;
    logic rise;
    int   f;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    m    = (v & m_h1) | (v & m_h2) | (m_h1 & m_h2);
    m_h2 = m_h1;
    m_h1 = v;
`else
    m = v;
`endif
    f      = e + PIPE;
    rise   = m & ~m_prev;
    m_prev = m;
    if (!m_measure) begin
      if (rise) begin
        m_measure = 1'b1;
        m_len = 1;
        m_hc  = 1;
      end else if (f == m_deadline) begin
        push_exp('0, 1'b0, f);
        m_deadline = m_deadline + LIMIT;
      end
    end else begin
      if (rise) begin
        push_exp(sat_sample(m_hc), (m_len >= PP - TOL) && (m_len <= PP + TOL), f);
        m_len = 1;
        m_hc  = 1;
      end else if (m_len == LIMIT) begin
        push_exp(sat_sample(m_hc), 1'b0, f);
        m_len = 1;
        m_hc  = m ? 1 : 0;
      end else begin
        m_len++;
        if (m) m_hc++;
      end
    end
  endtask

  // Scoreboard: pop and compare on each valid pulse, check holding otherwise.
  task automatic scoreboard_cycle();
    logic [IB:0] exp_v;
    int          exp_c;
    if (sample_valid === 1'b1) begin
      n_valid++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid cyc=%0d got sample=%0d locked=%0b, required no pulse", cyc, sample, locked);
      end else begin
        exp_v = exp_q.pop_front();
        exp_c = exp_cyc_q.pop_front();
        if ({locked, sample} !== exp_v || exp_c != cyc) begin
          n_fail++;
          $display("FAIL sample_out cyc=%0d got sample=%0d locked=%0b, required sample=%0d locked=%0b at cyc=%0d",
                   cyc, sample, locked, exp_v[IB-1:0], exp_v[IB], exp_c);
        end
      end
      hold_s = sample;
      hold_l = locked;
    end else begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        n_tests++;
        n_fail++;
        exp_v = exp_q.pop_front();
        exp_c = exp_cyc_q.pop_front();
        $display("FAIL missing_valid cyc=%0d got no pulse, required sample=%0d locked=%0b at cyc=%0d",
                 cyc, exp_v[IB-1:0], exp_v[IB], exp_c);
      end
      n_tests++;
      if (sample !== hold_s || locked !== hold_l) begin
        n_fail++;
        $display("FAIL output_hold cyc=%0d got sample=%0d locked=%0b, required sample=%0d locked=%0b",
                 cyc, sample, locked, hold_s, hold_l);
      end
    end
  endtask

  // Driver tasks: every clock advance after reset goes through drive_bit.
  task automatic drive_bit(input logic v);
    @(negedge clk);
    scoreboard_cycle();
    pwm_in = v;
    model_step(v, cyc + 1);
  endtask

  task automatic drive_n(input logic v, input int n);
    for (int i = 0; i < n; i++) drive_bit(v);
  endtask

  task automatic drive_frame(input int len, input int high);
    for (int i = 0; i < len; i++) drive_bit(i < high);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    m_prev = 1'b0;
    m_h1 = 1'b0;
    m_h2 = 1'b0;
    m_measure = 1'b0;
    m_len = 0;
    m_hc = 0;
    m_deadline = cyc + LIMIT + 1;
    hold_s = '0;
    hold_l = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_tests++;
    if (sample !== '0) begin n_fail++; $display("FAIL reset_sample got %0d required 0", sample); end
    n_tests++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b required 0", sample_valid); end
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %0b required 0", locked); end
    n_tests++;
    if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_state got %0b required 0 (SYNC)", state_dbg); end
  endtask

  task automatic test_idle_sync();
    int snap;
    snap = n_valid;
    drive_n(1'b0, 2 * LIMIT + 50);
    n_tests++;
    if (n_valid - snap != 2) begin n_fail++; $display("FAIL idle_pulses got %0d required 2", n_valid - snap); end
    n_tests++;
    if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL idle_state got %0b required 0 (SYNC)", state_dbg); end
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL idle_locked got %0b required 0", locked); end
  endtask

  task automatic test_locked_stream();
    for (int k = 0; k < 4; k++) drive_frame(PP, 640);
    n_tests++;
    if (sample !== 6'd20) begin n_fail++; $display("FAIL stream_sample got %0d required 20", sample); end
    n_tests++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL stream_locked got %0b required 1", locked); end
    n_tests++;
    if (state_dbg !== 1'b1) begin n_fail++; $display("FAIL stream_state got %0b required 1 (MEASURE)", state_dbg); end
  endtask

  task automatic test_timeout_high();
    drive_n(1'b1, 2 * LIMIT + 100);
    n_tests++;
    if (sample !== 6'd63) begin n_fail++; $display("FAIL timeout_sample got %0d required 63", sample); end
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked got %0b required 0", locked); end
    drive_n(1'b0, 200);
  endtask

  task automatic test_short_frame();
    drive_frame(PP, 640);
    drive_frame(PP, 640);
    drive_frame(2000, 1000);
    for (int i = 0; i < PP; i++) begin
      drive_bit(i < 640);
      if (i == 10) begin
        n_tests++;
        if (sample !== 6'd31) begin n_fail++; $display("FAIL short_sample got %0d required 31", sample); end
        n_tests++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL short_locked got %0b required 0", locked); end
      end
    end
    drive_frame(PP, 640);
    n_tests++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL relock got %0b required 1", locked); end
  endtask

  task automatic test_reset_mid_frame();
    int snap;
    drive_frame(PP, 640);
    drive_frame(1000, 640);
    do_reset(1);
    n_tests++;
    if (sample !== '0) begin n_fail++; $display("FAIL midreset_sample got %0d required 0", sample); end
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL midreset_locked got %0b required 0", locked); end
    n_tests++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %0b required 0", sample_valid); end
    n_tests++;
    if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL midreset_state got %0b required 0 (SYNC)", state_dbg); end
    snap = n_valid;
    drive_n(1'b0, PP - 1000);
    drive_frame(PP, 640);
    n_tests++;
    if (n_valid != snap) begin n_fail++; $display("FAIL midreset_first_edge got %0d pulses required 0", n_valid - snap); end
    drive_frame(PP, 640);
    n_tests++;
    if (n_valid != snap + 1) begin n_fail++; $display("FAIL midreset_first_sample got %0d pulses required 1", n_valid - snap); end
  endtask

  task automatic test_glitch();
    drive_frame(PP, 640);
    for (int i = 0; i < PP; i++) drive_bit((i < 640) || (i == 1200));
    for (int i = 0; i < PP; i++) begin
      drive_bit(i < 640);
      if (i == 10) begin
`ifdef PWM_DEC_GLITCH_FILTER_EN
        n_tests++;
        if (sample !== 6'd20) begin n_fail++; $display("FAIL glitch_sample got %0d required 20", sample); end
        n_tests++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL glitch_locked got %0b required 1", locked); end
`else
        n_tests++;
        if (sample !== 6'd0) begin n_fail++; $display("FAIL glitch_sample got %0d required 0", sample); end
        n_tests++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL glitch_locked got %0b required 0", locked); end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    int high;
    for (int k = 0; k < 6; k++) begin
      len  = $urandom_range(PP - 8, PP + 10);
      high = $urandom_range(1, len - 1);
      drive_frame(len, high);
    end
    drive_bit(1'b0);
    drive_n(1'b1, 10);
  endtask

  task automatic test_drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      drive_bit(pwm_in);
      k++;
    end
    drive_n(pwm_in, 4);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending samples required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_idle_sync();
    test_locked_stream();
    test_timeout_high();
    test_short_frame();
    test_reset_mid_frame();
    test_glitch();
    test_back_to_back();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 The module SHALL have parameter PULSE_PERIOD, default 2048, giving the nominal PWM frame length in clk cycles; it SHALL be a power of two.
REQ-002 The module SHALL have parameter INPUT_BITS, default 6, giving the recovered sample width; it SHALL satisfy 2^INPUT_BITS <= PULSE_PERIOD.
REQ-003 The module SHALL have parameter TOLERANCE, default 2, giving the allowed frame-length deviation in clk cycles.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The module SHALL have port pwm_in, input, 1 bit, an asynchronous PWM waveform.
REQ-007 The module SHALL have port sample, output, INPUT_BITS bits, the last recovered value.
REQ-008 The module SHALL have port sample_valid, output, 1 bit, a one-cycle pulse marking a new sample.
REQ-009 The module SHALL have port locked, output, 1 bit, high while frames match PULSE_PERIOD within TOLERANCE.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; all logic below SHALL use the synchronized signal s and its one-cycle-delayed copy.
REQ-011 A rising edge SHALL be s=1 while the delayed copy is 0.
REQ-012 The FSM SHALL have two states: SYNC (after reset, no frame reference) and MEASURE.
REQ-013 In SYNC, the first rising edge SHALL move the FSM to MEASURE with period_cnt=1 and high_cnt=1, and SHALL NOT emit a sample.
REQ-014 In MEASURE, each cycle without a rising edge SHALL increment period_cnt and SHALL increment high_cnt when s=1.
REQ-015 In MEASURE, a rising edge SHALL end the frame: emit a sample from high_cnt, then restart with period_cnt=1 and high_cnt=1.
REQ-016 The sample SHALL be high_cnt >> (log2(PULSE_PERIOD) - INPUT_BITS), saturated to 2^INPUT_BITS-1.
REQ-017 high_cnt SHALL be log2(PULSE_PERIOD)+1 bits wide, and period_cnt SHALL be wide enough to reach PULSE_PERIOD+TOLERANCE with no wrap.
REQ-018 Timeout: when period_cnt reaches PULSE_PERIOD+TOLERANCE without a rising edge, the module SHALL emit a sample from high_cnt, deassert locked, and restart with period_cnt=1 and high_cnt=s.
REQ-019 In SYNC, a timeout (period_cnt counting from reset) SHALL emit sample=0 and remain in SYNC.
REQ-020 If a rising edge and the timeout condition occur in the same cycle, the rising edge SHALL take priority.
REQ-021 An edge-terminated frame of length within PULSE_PERIOD±TOLERANCE SHALL set locked=1 in the cycle sample_valid is asserted; any other frame length SHALL clear locked in that same cycle.
REQ-022 sample and locked SHALL be registered and SHALL hold their values between sample_valid pulses.
REQ-023 sample_valid SHALL assert exactly 3 clk cycles after the first clk edge that samples pwm_in high at a frame boundary, and exactly 1 cycle after the timeout condition.

Reset
REQ-024 Reset SHALL take priority over all other events.
REQ-025 The cycle after reset is sampled high, the module SHALL be in SYNC, synchronizer and filter flops SHALL be 0, counters SHALL be 0, sample SHALL be 0, sample_valid SHALL be 0, and locked SHALL be 0.
REQ-026 Reset mid-frame SHALL discard the partial frame, and the next rising edge SHALL NOT emit.

Configuration
REQ-027 When macro PWM_DEC_GLITCH_FILTER_EN is defined, s SHALL be the registered 3-sample majority of the synchronizer output, which adds 2 cycles to the latency in REQ-023 (5 cycles for edges).
REQ-028 When PWM_DEC_GLITCH_FILTER_EN is undefined, s SHALL be the raw synchronizer output, with no filter logic.

Verification (PULSE_PERIOD=2048, INPUT_BITS=6, TOLERANCE=2; shift 5)
REQ-029 Frames of 640 clk high in 2048 -> sample=20 once per frame; first emission one frame after the first edge; locked=1 from the first emission.
REQ-030 Locked stream, then pwm_in held high -> timeout at period_cnt=2050 emits sample=63 with locked=0, repeating every 2050 cycles.
REQ-031 pwm_in low from reset -> sample_valid with sample=0 every 2050 cycles, locked stays 0, FSM stays in SYNC.
REQ-032 Locked stream, then one frame of 2000 cycles with 1000 high -> sample=31 and locked=0; the next 2048-cycle frame -> locked=1.
REQ-033 Reset asserted mid-frame at 1000 cycles -> all outputs 0 the next cycle, no sample_valid on the next rising edge, first sample one full frame later.
REQ-034 One-cycle high glitch at cycle 1200 of a 640/2048 frame -> with PWM_DEC_GLITCH_FILTER_EN: ignored, sample=20, locked=1; without it: the frame ends early and locked=0.
